field_vec_scatter: RTL and testbench

FIELD_VEC_SCATTER -- requirements
Module: field_vec_scatter

---
 rtl/field_vec_scatter.sv | 89 ++++++++
 tb/tb_field_vec_scatter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/field_vec_scatter.sv
// Streams ngates field elements into a registered bank that feeds an adder tree.
// The all-ones encoding of p = 2^61-1 is folded to zero as each element is written.
module field_vec_scatter #(
  parameter int ngates  = 8,
  parameter int F_NBITS = 61
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [F_NBITS-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [F_NBITS-1:0] v_parts [ngates-1:0],
  output logic               busy,
  output logic               done,
  output logic               dbg_state
);

  localparam int IDX_W = $clog2(ngates) + 1;
  localparam logic [F_NBITS-1:0] P_MOD = {F_NBITS{1'b1}};

  typedef enum logic {IDLE = 1'b0, LOAD = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               done_q, done_d;
  logic               xfer;
  logic [F_NBITS-1:0] red_data;
  logic [F_NBITS-1:0] bank_q [ngates-1:0];

  // Handshake: a transfer happens on any edge where in_valid && in_ready.
  // in_ready depends on the state alone, so a producer may hold in_valid
  // low indefinitely without affecting bank contents, idx or state.
  assign in_ready  = (state_q == LOAD);
  assign xfer      = in_ready && in_valid;
  assign red_data  = (in_data == P_MOD) ? '0 : in_data;
  assign busy      = (state_q == LOAD);
  assign done      = done_q;
  assign dbg_state = state_q;
  assign v_parts   = bank_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (xfer) begin
          idx_d = idx_q + 1'b1;
          if (idx_q == IDX_W'(ngates - 1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Entries are only rewritten by transfers; start leaves old contents in place.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ngates; i++) begin
      if (rst) begin
        bank_q[i] <= '0;
      end else if (xfer && (idx_q == IDX_W'(i))) begin
        bank_q[i] <= red_data;
      end
    end
  end

endmodule

// File: tb/tb_field_vec_scatter.sv
// Directed bench for field_vec_scatter: ngates=8 main instance, plus ngates=1
// and ngates=237 instances (the latter summed by a behavioural adder tree).
module tb_field_vec_scatter;

  localparam logic [60:0] PMAX = {61{1'b1}};
  localparam logic [60:0] PM1  = {{60{1'b1}}, 1'b0};

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ngates = 8
  logic        start8 = 0, valid8 = 0, ready8, busy8, done8, dbg8;
  logic [60:0] data8 = '0;
  logic [60:0] v8 [7:0];
  field_vec_scatter #(.ngates(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .in_data(data8), .in_valid(valid8),
    .in_ready(ready8), .v_parts(v8), .busy(busy8), .done(done8), .dbg_state(dbg8));

  // ngates = 1
  logic        start1 = 0, valid1 = 0, ready1, busy1, done1, dbg1;
  logic [60:0] data1 = '0;
  logic [60:0] v1 [0:0];
  field_vec_scatter #(.ngates(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .in_data(data1), .in_valid(valid1),
    .in_ready(ready1), .v_parts(v1), .busy(busy1), .done(done1), .dbg_state(dbg1));

  // ngates = 237
  logic        start_b = 0, valid_b = 0, ready_b, busy_b, done_b, dbg_b;
  logic [60:0] data_b = '0;
  logic [60:0] vb [236:0];
  field_vec_scatter #(.ngates(237)) dutb (
    .clk(clk), .rst(rst), .start(start_b), .in_data(data_b), .in_valid(valid_b),
    .in_ready(ready_b), .v_parts(vb), .busy(busy_b), .done(done_b), .dbg_state(dbg_b));

  logic [63:0] tree_sum;
  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < 237; i++) tree_sum = tree_sum + 64'(vb[i]);
  end

  // scoreboard
  int n_checks = 0;
  int n_errors = 0;
  logic [60:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks: inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load8();
    start8 = 1;
    step();
    start8 = 0;
  endtask

  task automatic send8(input logic [60:0] val);
    valid8 = 1;
    data8  = val;
    step();
    valid8 = 0;
  endtask

  task automatic check_bank8(input string tag);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_v%0d", tag, i), 64'(v8[i]), 64'(exp_q[i]));
    end
  endtask

  initial begin
    logic [63:0] ref_sum;
    logic [60:0] val;
    int          wait_cnt;

    // reset
    rst = 1;
    step(); step();
    rst = 0;
    check("rst_busy", 64'(busy8), 64'd0);
    check("rst_done", 64'(done8), 64'd0);
    check("rst_ready", 64'(ready8), 64'd0);
    check("rst_v0", 64'(v8[0]), 64'd0);
    check("rst_v7", 64'(v8[7]), 64'd0);

    // in_valid while IDLE writes nothing
    valid8 = 1; data8 = 61'd99;
    step(); step();
    valid8 = 0;
    check("idle_nowrite", 64'(v8[0]), 64'd0);
    check("idle_busy", 64'(busy8), 64'd0);

    // back-to-back 1..8
    start_load8();
    check("start_busy", 64'(busy8), 64'd1);
    check("start_ready", 64'(ready8), 64'd1);
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      send8(61'(k + 1));
      exp_q.push_back(61'(k + 1));
      check($sformatf("b2b_done%0d", k), 64'(done8), (k == 7) ? 64'd1 : 64'd0);
    end
    check("b2b_busy", 64'(busy8), 64'd0);
    check_bank8("b2b");
    step();
    check("b2b_done_pulse", 64'(done8), 64'd0);

    // in_valid toggled 1,0,0 with values 10..17
    start_load8();
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      send8(61'(10 + k));
      exp_q.push_back(61'(10 + k));
      if (k < 7) begin
        check($sformatf("gap_done%0d", k), 64'(done8), 64'd0);
        step(); step();
        check($sformatf("gap_hold_busy%0d", k), 64'(busy8), 64'd1);
        check($sformatf("gap_hold_v%0d", k), 64'(v8[k]), 64'(10 + k));
      end
    end
    check("gap_done", 64'(done8), 64'd1);
    check_bank8("gap");

    // reduction of p and p-1; stale entries survive a new start
    step();
    start_load8();
    send8(PMAX);
    send8(PM1);
    check("red_v0", 64'(v8[0]), 64'd0);
    check("red_v1", 64'(v8[1]), 64'(PM1));
    check("stale_v2", 64'(v8[2]), 64'd12);
    for (int k = 2; k < 8; k++) send8(61'(100 + k));
    check("red_done", 64'(done8), 64'd1);

    // reset mid-load, colliding with start and a transfer
    step();
    start_load8();
    send8(61'd200); send8(61'd201); send8(61'd202);
    rst = 1; start8 = 1; valid8 = 1; data8 = 61'd203;
    step();
    rst = 0; start8 = 0; valid8 = 0;
    check("mid_rst_busy", 64'(busy8), 64'd0);
    check("mid_rst_done", 64'(done8), 64'd0);
    for (int i = 0; i < 8; i++) check($sformatf("mid_rst_v%0d", i), 64'(v8[i]), 64'd0);
    step();
    check("mid_rst_nodone", 64'(done8), 64'd0);
    start_load8();
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      send8(61'(3 * (k + 1)));
      exp_q.push_back(61'(3 * (k + 1)));
    end
    check("reload_done", 64'(done8), 64'd1);
    check_bank8("reload");

    // start mid-load is ignored; in_valid in IDLE writes nothing
    step();
    start_load8();
    send8(61'd40); send8(61'd41);
    start8 = 1;
    send8(61'd50);
    start8 = 0;
    check("midstart_busy", 64'(busy8), 64'd1);
    check("midstart_v0", 64'(v8[0]), 64'd40);
    check("midstart_v2", 64'(v8[2]), 64'd50);
    for (int k = 3; k < 8; k++) begin
      send8(61'(50 + k));
      check($sformatf("midstart_done%0d", k), 64'(done8), (k == 7) ? 64'd1 : 64'd0);
    end
    valid8 = 1; data8 = 61'd77;
    step(); step();
    valid8 = 0;
    check("post_idle_v0", 64'(v8[0]), 64'd40);
    check("post_idle_v7", 64'(v8[7]), 64'd57);

    // ngates = 1
    start1 = 1; step(); start1 = 0;
    check("g1_busy", 64'(busy1), 64'd1);
    valid1 = 1; data1 = 61'd42; step(); valid1 = 0;
    check("g1_done", 64'(done1), 64'd1);
    check("g1_busy_done", 64'(busy1), 64'd0);
    check("g1_v0", 64'(v1[0]), 64'd42);
    step();
    check("g1_done_pulse", 64'(done1), 64'd0);
    start1 = 1; step(); start1 = 0;
    valid1 = 1; data1 = PMAX; step(); valid1 = 0;
    check("g1_red", 64'(v1[0]), 64'd0);

    // ngates = 237 into an adder tree
    exp_q.delete();
    ref_sum = '0;
    start_b = 1; step(); start_b = 0;
    for (int k = 0; k < 237; k++) begin
      val = 61'($urandom());
      exp_q.push_back(val);
      ref_sum = ref_sum + 64'(val);
      valid_b = 1; data_b = val;
      step();
    end
    valid_b = 0;
    wait_cnt = 0;
    while (!done_b && wait_cnt < 4) begin
      step();
      wait_cnt++;
    end
    check("g237_done", 64'(done_b), 64'd1);
    check("g237_sum", tree_sum, ref_sum);
    check("g237_first", 64'(vb[0]), 64'(exp_q[0]));
    check("g237_last", 64'(vb[236]), 64'(exp_q[236]));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
